// File: rtl/frontend_pkg.sv
// rtl/frontend_pkg.sv - frontend bundle layout, width and pack/unpack helpers
package frontend_pkg;

    localparam int BUNDLE_W = 256;
    localparam int INS_W    = 96;
    localparam int PC_W     = 40;
    localparam int BTB_TGT_W = 16;

    // Fields are listed MSB first, so ins0 occupies bits [95:0].
    typedef struct packed {
        logic                 btb_way;
        logic [1:0]           btb_idx;
        logic                 btb_vld;
        logic [BTB_TGT_W-1:0] btb_target;
        logic                 btb_pred;
        logic [2:0]           btb_type;
        logic [PC_W-1:0]      pc;
        logic [INS_W-1:0]     ins1;
        logic [INS_W-1:0]     ins0;
    } bundle_t;

    localparam int INS0_LSB     = 0;
    localparam int INS1_LSB     = INS0_LSB + INS_W;
    localparam int PC_LSB       = INS1_LSB + INS_W;
    localparam int BTB_TYPE_LSB = PC_LSB + PC_W;
    localparam int BTB_PRED_LSB = BTB_TYPE_LSB + 3;
    localparam int BTB_TGT_LSB  = BTB_PRED_LSB + 1;
    localparam int BTB_VLD_LSB  = BTB_TGT_LSB + BTB_TGT_W;
    localparam int BTB_IDX_LSB  = BTB_VLD_LSB + 1;
    localparam int BTB_WAY_LSB  = BTB_IDX_LSB + 2;

    function automatic logic [BUNDLE_W-1:0] pack_bundle(input bundle_t b);
        return b;
    endfunction

    function automatic bundle_t unpack_bundle(input logic [BUNDLE_W-1:0] raw);
        return bundle_t'(raw);
    endfunction

    function automatic logic [1:0] ins_weight(input logic ins1_valid);
        return ins1_valid ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - wrap-bit pointer pair with occupancy count and flush
module fifo_ptr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   wr_ptr,
    output logic [$clog2(DEPTH):0]   rd_ptr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH) + 1;

    // DEPTH is a power of two, so a plain increment wraps the index and toggles the wrap bit.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + PW'(push) - PW'(pop);
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        count == PW'(wr_ptr - rd_ptr));

endmodule

// File: rtl/decode_rename_queue.sv
// rtl/decode_rename_queue.sv - decoded-bundle FIFO between decode and rename
module decode_rename_queue #(
    parameter int DEPTH    = 4,
    parameter int BUNDLE_W = frontend_pkg::BUNDLE_W
) (
    input  logic                       core_clock_i,
    input  logic                       core_reset_i,
    input  logic                       core_flush_i,
    input  logic                       fe_valid_i,
    input  logic [BUNDLE_W-1:0]        fe_bundle_i,
    input  logic                       fe_ins1_valid_i,
    output logic                       fe_busy_o,
    output logic                       rn_valid_o,
    output logic [BUNDLE_W-1:0]        rn_bundle_o,
    output logic                       rn_ins1_valid_o,
    input  logic                       rn_busy_i,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [$clog2(DEPTH)+1:0]   ins_count_o
);
    import frontend_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = AW + 2;

    logic [BUNDLE_W:0] mem [DEPTH];
    logic [CW-1:0]     wr_ptr, rd_ptr, count;
    logic [IW-1:0]     ins_count;
    logic              full, empty, push, pop;
    logic [BUNDLE_W:0] head;

    assign fe_busy_o  = (count == CW'(DEPTH));
    assign rn_valid_o = (count != '0);
    assign push = fe_valid_i & ~fe_busy_o & ~core_flush_i;
    assign pop  = rn_valid_o & ~rn_busy_i & ~core_flush_i;

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk    (core_clock_i),
        .rst    (core_reset_i),
        .flush  (core_flush_i),
        .push   (push),
        .pop    (pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge core_clock_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {fe_ins1_valid_i, fe_bundle_i};
    end

    // mem is never reset; gating on valid keeps X out of rename after reset.
    assign head            = mem[rd_ptr[AW-1:0]];
    assign rn_bundle_o     = rn_valid_o ? head[BUNDLE_W-1:0] : '0;
    assign rn_ins1_valid_o = rn_valid_o ? head[BUNDLE_W] : 1'b0;

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i || core_flush_i) begin
            ins_count <= '0;
        end else begin
            ins_count <= ins_count
                       + (push ? IW'(ins_weight(fe_ins1_valid_i)) : IW'(0))
                       - (pop  ? IW'(ins_weight(rn_ins1_valid_o)) : IW'(0));
        end
    end

    assign occupancy_o = count;
    assign ins_count_o = ins_count;

    a_no_push_full: assert property (@(posedge core_clock_i) disable iff (core_reset_i)
        push |-> !full);
    a_no_pop_empty: assert property (@(posedge core_clock_i) disable iff (core_reset_i)
        pop |-> !empty);
    a_ins1_needs_valid: assert property (@(posedge core_clock_i) disable iff (core_reset_i)
        !fe_valid_i |-> !push);
    a_busy_is_full: assert property (@(posedge core_clock_i) disable iff (core_reset_i)
        fe_busy_o == full);

endmodule

// File: tb/tb_decode_rename_queue.sv
// tb/tb_decode_rename_queue.sv - randomized and directed bench against a queue model
module tb_decode_rename_queue;
    localparam int DEPTH = 4;
    localparam int BW    = 256;

    logic          core_clock_i = 1'b0;
    logic          core_reset_i, core_flush_i, fe_valid_i, fe_ins1_valid_i, rn_busy_i;
    logic [BW-1:0] fe_bundle_i, rn_bundle_o;
    logic          fe_busy_o, rn_valid_o, rn_ins1_valid_o;
    logic [2:0]    occupancy_o;
    logic [3:0]    ins_count_o;

    decode_rename_queue #(.DEPTH(DEPTH), .BUNDLE_W(BW)) dut (
        .core_clock_i    (core_clock_i),
        .core_reset_i    (core_reset_i),
        .core_flush_i    (core_flush_i),
        .fe_valid_i      (fe_valid_i),
        .fe_bundle_i     (fe_bundle_i),
        .fe_ins1_valid_i (fe_ins1_valid_i),
        .fe_busy_o       (fe_busy_o),
        .rn_valid_o      (rn_valid_o),
        .rn_bundle_o     (rn_bundle_o),
        .rn_ins1_valid_o (rn_ins1_valid_o),
        .rn_busy_i       (rn_busy_i),
        .occupancy_o     (occupancy_o),
        .ins_count_o     (ins_count_o)
    );

    always #5 core_clock_i = ~core_clock_i;

    typedef struct {
        logic [BW-1:0] bundle;
        logic          ins1;
    } entry_t;

    entry_t model_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", tag, obs, exp);
    endtask

    function automatic logic [BW-1:0] rand_bundle();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int model_ins();
        int s = 0;
        foreach (model_q[i]) s += model_q[i].ins1 ? 2 : 1;
        return s;
    endfunction

    task automatic compare_all();
        check("rn_valid", rn_valid_o, model_q.size() != 0);
        check("fe_busy", fe_busy_o, model_q.size() == DEPTH);
        check("occupancy", occupancy_o, model_q.size());
        check("ins_count", ins_count_o, model_ins());
        check("rn_bundle", rn_bundle_o, model_q.size() != 0 ? model_q[0].bundle : '0);
        check("rn_ins1", rn_ins1_valid_o, model_q.size() != 0 ? model_q[0].ins1 : 1'b0);
    endtask

    // Called at a negedge: drive inputs, advance the model, sample at the next negedge.
    task automatic step(input logic rst, input logic flush, input logic fv, input logic ins1,
                        input logic busy, input logic [BW-1:0] b);
        logic do_push, do_pop;
        entry_t e;
        core_reset_i = rst; core_flush_i = flush; fe_valid_i = fv;
        fe_ins1_valid_i = ins1; rn_busy_i = busy; fe_bundle_i = b;
        do_push = fv && model_q.size() < DEPTH && !flush;
        do_pop  = model_q.size() != 0 && !busy && !flush;
        if (rst || flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.bundle = b; e.ins1 = ins1;
                model_q.push_back(e);
            end
        end
        @(posedge core_clock_i);
        @(negedge core_clock_i);
        compare_all();
    endtask

    logic [BW-1:0] bun[5];
    logic [BW-1:0] x;

    initial begin
        core_reset_i = 1'b1; core_flush_i = 1'b0; fe_valid_i = 1'b0;
        fe_ins1_valid_i = 1'b0; rn_busy_i = 1'b1; fe_bundle_i = '0;
        repeat (2) @(posedge core_clock_i);
        @(negedge core_clock_i);
        step(1, 0, 0, 0, 1, '0);
        check("reset_busy", fe_busy_o, 1'b0);
        check("reset_bundle", rn_bundle_o, '0);

        // Fill with A-D while rename stalls.
        for (int i = 0; i < 5; i++) bun[i] = rand_bundle();
        step(0, 0, 1, 1, 1, bun[0]);
        step(0, 0, 1, 0, 1, bun[1]);
        step(0, 0, 1, 1, 1, bun[2]);
        step(0, 0, 1, 1, 1, bun[3]);
        check("t1_busy", fe_busy_o, 1'b1);
        check("t1_occ", occupancy_o, 3'd4);
        check("t1_ins", ins_count_o, 4'd7);
        check("t1_head", rn_bundle_o, bun[0]);

        // Full queue pops A but refuses E the same cycle.
        step(0, 0, 1, 0, 0, bun[4]);
        check("t2_occ3", occupancy_o, 3'd3);
        check("t2_head", rn_bundle_o, bun[1]);
        step(0, 0, 1, 0, 1, bun[4]);
        check("t2_occ4", occupancy_o, 3'd4);
        repeat (5) step(0, 0, 0, 0, 0, '0);

        // Streaming: one push and one pop per cycle.
        for (int i = 0; i < 20; i++) begin
            x = rand_bundle();
            step(0, 0, 1, 1'($urandom), 0, x);
            check("t3_latency", rn_bundle_o, x);
        end
        step(0, 0, 0, 0, 0, '0);

        // Flush with a simultaneous push.
        repeat (3) step(0, 0, 1, 1, 1, rand_bundle());
        x = rand_bundle();
        step(0, 1, 1, 1, 0, x);
        check("t4_valid", rn_valid_o, 1'b0);
        check("t4_ins", ins_count_o, 4'd0);
        repeat (3) step(0, 0, 0, 0, 0, '0);

        // Idle empty queue.
        repeat (10) step(0, 0, 0, 1, 0, '0);

        // Reset with bundles held and a push pending.
        repeat (2) step(0, 0, 1, 0, 1, rand_bundle());
        step(1, 0, 1, 1, 1, rand_bundle());
        x = rand_bundle();
        step(0, 0, 1, 0, 1, x);
        check("t6_first", rn_bundle_o, x);
        check("t6_occ", occupancy_o, 3'd1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 2) != 0, 1'($urandom),
                 $urandom_range(0, 2) == 0, rand_bundle());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
